// File: rtl/i2c_word_receiver.sv
// Write-only I2C slave that packs every 4 received bytes (big-endian) into a 32-bit word for a
// valid/ready loader. Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_word_receiver #(
   parameter logic [6:0]  I2C_ADDR = 7'h08,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             MAX10_CLK1_50,
   input  logic             RESET_N,
   input  logic             SCL,
   inout  wire              SDA,
   input  logic             FINISH,
   output logic [31:0]      WORD_DATA,
   output logic             WORD_VALID,
   input  logic             WORD_READY,
   output logic             LOAD_DONE,
   output logic             OVERFLOW,
   output logic [CNT_W-1:0] WORD_COUNT
);

   typedef enum logic [2:0] {StIdle, StAddr, StAddrAck, StData, StDataAck, StIgnore} state_t;

   localparam logic [CNT_W-1:0] CntOne = 1;

   logic [1:0] scl_sync, sda_sync, fin_sync;
   logic       scl_f, sda_f;

   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         fin_sync <= 2'b00;
      end else begin
         scl_sync <= {scl_sync[0], SCL};
         sda_sync <= {sda_sync[0], SDA};
         fin_sync <= {fin_sync[0], FINISH};
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_hist, sda_hist;
   logic       scl_maj, sda_maj;

   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_maj  <= 1'b1;
         sda_maj  <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_maj  <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                     (scl_hist[0] & scl_hist[1]);
         sda_maj  <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                     (sda_hist[0] & sda_hist[1]);
      end
   end

   assign scl_f = scl_maj;
   assign sda_f = sda_maj;
`else
   assign scl_f = scl_sync[1];
   assign sda_f = sda_sync[1];
`endif

   logic scl_q, sda_q, fin_q;
   logic scl_rise, scl_fall, start_det, stop_det, fin_rise;

   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;
   assign start_det = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
   assign fin_rise  = fin_sync[1] & ~fin_q;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [6:0]       shift_q, shift_d;
   logic [23:0]      word_buf_q, word_buf_d;
   logic             sda_oe_q, sda_oe_d;
   logic [31:0]      word_data_q, word_data_d;
   logic             word_valid_q, word_valid_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             load_done_q, load_done_d;
   logic [7:0]       byte_in;
   logic             xfer, fire;

   assign byte_in = {shift_q, sda_f};
   assign xfer    = word_valid_q & WORD_READY;
   assign fire    = done_q & ~word_valid_q;

   always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         scl_q        <= 1'b1;
         sda_q        <= 1'b1;
         fin_q        <= 1'b0;
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         word_buf_q   <= '0;
         sda_oe_q     <= 1'b0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         count_q      <= '0;
         done_q       <= 1'b0;
         load_done_q  <= 1'b0;
      end else begin
         scl_q        <= scl_f;
         sda_q        <= sda_f;
         fin_q        <= fin_sync[1];
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         word_buf_q   <= word_buf_d;
         sda_oe_q     <= sda_oe_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         overflow_q   <= overflow_d;
         count_q      <= count_d;
         done_q       <= done_d;
         load_done_q  <= load_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      word_buf_d   = word_buf_q;
      sda_oe_d     = sda_oe_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q & ~xfer;
      overflow_d   = overflow_q;
      count_d      = xfer ? count_q + CntOne : count_q;
      done_d       = fin_rise | (done_q & ~fire);
      load_done_d  = fire;

      if (start_det) begin
         state_d    = StAddr;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         sda_oe_d   = 1'b0;
      end else if (stop_det) begin
         state_d    = StIdle;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         sda_oe_d   = 1'b0;
      end else begin
         unique case (state_q)
            StAddr: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = (byte_in == {I2C_ADDR, 1'b0}) ? StAddrAck : StIgnore;
                  end
               end
            end
            // First SCL fall after the 8th bit starts the ACK, the next one ends it.
            StAddrAck, StDataAck: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = StData;
                  end
               end
            end
            StData: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     byte_cnt_d = byte_cnt_q + 2'd1;
                     if (byte_cnt_q != 2'd3) begin
                        word_buf_d = {word_buf_q[15:0], byte_in};
                        state_d    = StDataAck;
                     end else if (!word_valid_q || xfer) begin
                        word_data_d  = {word_buf_q, byte_in};
                        word_valid_d = 1'b1;
                        state_d      = StDataAck;
                     end else begin
                        overflow_d = 1'b1;
                        state_d    = StIgnore;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
   assign WORD_DATA  = word_data_q;
   assign WORD_VALID = word_valid_q;
   assign LOAD_DONE  = load_done_q;
   assign OVERFLOW   = overflow_q;
   assign WORD_COUNT = count_q;

endmodule

// File: doc/i2c_word_receiver.md
I2C_WORD_RECEIVER -- requirements
Module: i2c_word_receiver

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h08, 7-bit slave address answered.
REQ-002 SHALL have parameter CNT_W, default 16, width of WORD_COUNT.
REQ-003 SHALL have port MAX10_CLK1_50 input 1 system clock, 50 MHz.
REQ-004 SHALL have port RESET_N input 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port SCL input 1, I2C clock from the Arduino master.
REQ-006 SHALL have port SDA inout 1, open-drain I2C data; driven 0 or Z only, never 1.
REQ-007 SHALL have port FINISH input 1, asynchronous end-of-transfer level from the Arduino.
REQ-008 SHALL have port WORD_DATA output 32, assembled word to the SDRAM loader.
REQ-009 SHALL have port WORD_VALID output 1, WORD_DATA holds an unconsumed word.
REQ-010 SHALL have port WORD_READY input 1, loader accepts the word this cycle.
REQ-011 SHALL have port LOAD_DONE output 1, one-cycle pulse at end of load.
REQ-012 SHALL have port OVERFLOW output 1, sticky, a word was dropped.
REQ-013 SHALL have port WORD_COUNT output CNT_W, words handed to the loader since reset.

Function
REQ-014 SHALL pass SCL, SDA and FINISH through 2-flop synchronizers; all edge detection uses synchronized values.
REQ-015 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-016 SHALL sample SDA on SCL rising and change its own SDA drive only after SCL falling.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-018 SHALL enter ADDR from any state on START, including repeated START; byte and bit counters clear.
REQ-019 SHALL go ADDR -> ADDR_ACK after 8 bits when addr==I2C_ADDR and R/W==0, else ADDR -> IGNORE with SDA released (NACK).
REQ-020 SHALL drive SDA low in ADDR_ACK and DATA_ACK for exactly the 9th SCL pulse, then release it and go to DATA.
REQ-021 SHALL shift data MSB first and pack big-endian: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-022 SHALL, on the 4th byte, load WORD_DATA and set WORD_VALID on the cycle after the 8th bit is sampled, when WORD_VALID is low.
REQ-023 SHALL, if WORD_VALID is still high at the 4th byte, drop the word, NACK that byte, set OVERFLOW and leave WORD_DATA unchanged.
REQ-024 SHALL complete a transfer when WORD_VALID & WORD_READY: WORD_VALID clears next cycle and WORD_COUNT increments, wrapping at 2^CNT_W.
REQ-025 SHALL, when transfer and a new 4th byte occur in the same cycle, accept the new word with WORD_VALID staying high and no OVERFLOW.
REQ-026 SHALL hold WORD_DATA stable while WORD_VALID is high.
REQ-027 SHALL discard a partial word (1-3 bytes) on STOP or START, and go to IDLE on STOP.
REQ-028 SHALL, on the synchronized FINISH rising edge, arm a done flag and pulse LOAD_DONE for 1 cycle when armed and WORD_VALID is low; the flag then clears.
REQ-029 SHALL ignore bus activity in IGNORE until the next START or STOP.

Reset
REQ-030 SHALL, on RESET_N low, asynchronously force: state IDLE, SDA released (Z), WORD_DATA 0, WORD_VALID 0, LOAD_DONE 0, OVERFLOW 0, WORD_COUNT 0, synchronizers to 1 (bus idle), FINISH sync and done flag to 0.
REQ-031 SHALL, when reset is asserted mid-byte or mid-ACK, release SDA immediately and resume only at the next START after deassertion.

Configuration
REQ-032 SHALL, with I2C_GLITCH_FILTER_EN defined, add a 3-sample majority filter after the synchronizers on SCL and SDA, 2 extra cycles latency, rejecting pulses of 1 cycle or shorter.
REQ-033 SHALL, without I2C_GLITCH_FILTER_EN, use synchronizer outputs directly with no filtering.

Verification
REQ-034 SHALL cover: START, 0x10 (addr 0x08 W), DE AD BE EF, STOP -> 5 ACKs, WORD_DATA=32'hDEADBEEF, WORD_VALID=1; READY=1 gives WORD_COUNT=1.
REQ-035 SHALL cover: address 0x09 W, or 0x11 (read) -> NACK on 9th bit, SDA never driven low, no WORD_VALID.
REQ-036 SHALL cover: READY held 0, two words 11223344 then 55667788 -> 8th byte NACKed, OVERFLOW=1, WORD_DATA stays 32'h11223344.
REQ-037 SHALL cover: AA BB then STOP, then new frame 01 02 03 04 -> WORD_DATA=32'h01020304, no AABB residue.
REQ-038 SHALL cover: FINISH rises with WORD_VALID=1 -> LOAD_DONE stays 0 until READY completes the transfer, then exactly one 1-cycle pulse.
REQ-039 SHALL cover: RESET_N low during the 2nd data byte ACK -> SDA released same cycle, all outputs at reset values, next frame received correctly.
